// File: rtl/hh_mm_pkg.sv
// Shared types and constants for the hh:mm clock-setting controller.
// Alarm states exist only when HH_MM_ALARM_EN is defined.
package hh_mm_pkg;

    localparam logic [4:0] HOUR_MAX     = 5'd23;
    localparam logic [2:0] MIN_TENS_MAX = 3'd5;
    localparam logic [3:0] MIN_ONES_MAX = 4'd9;

    typedef enum logic [2:0] {
        RUN      = 3'd0,
        SET_HOUR = 3'd1,
        SET_MIN  = 3'd2
`ifdef HH_MM_ALARM_EN
        ,
        AL_HOUR  = 3'd3,
        AL_MIN   = 3'd4
`endif
    } state_t;

    typedef enum logic {
        FIELD_HOUR = 1'b0,
        FIELD_MIN  = 1'b1
    } field_t;

    typedef struct packed {
        logic [4:0] hour;
        logic [2:0] min_tens;
        logic [3:0] min_ones;
    } hh_mm_t;

`ifdef HH_MM_ALARM_EN
    localparam hh_mm_t ALARM_RESET = '{hour: 5'd6, min_tens: 3'd0, min_ones: 4'd0};
`endif

    function automatic logic [4:0] next_hour(input logic [4:0] h);
        return (h == HOUR_MAX) ? 5'd0 : h + 5'd1;
    endfunction

endpackage

// File: rtl/hh_mm_incr.sv
// Combinational hh:mm incrementer: bumps either the hour or the minutes,
// with an optional minute-to-hour carry when the minutes wrap.
module hh_mm_incr
    import hh_mm_pkg::*;
(
    input  hh_mm_t cur,
    input  logic   carry_en,
    input  field_t field,
    output hh_mm_t nxt
);

    always_comb begin
        // NOTE: default assignment first so no branch leaves nxt unassigned (no latch).
        nxt = cur;
        if (field == FIELD_HOUR) begin
            nxt.hour = next_hour(cur.hour);
        end else if (cur.min_ones != MIN_ONES_MAX) begin
            nxt.min_ones = cur.min_ones + 4'd1;
        end else begin
            nxt.min_ones = 4'd0;
            if (cur.min_tens != MIN_TENS_MAX) begin
                nxt.min_tens = cur.min_tens + 3'd1;
            end else begin
                nxt.min_tens = 3'd0;
                if (carry_en) nxt.hour = next_hour(cur.hour);
            end
        end
    end

endmodule

// File: rtl/hh_mm_set_controller.sv
// Clock time-setting controller with blinking edit field.
// Define HH_MM_ALARM_EN to add the alarm register, alarm edit states and alarm_out.
module hh_mm_set_controller
    import hh_mm_pkg::*;
#(
    parameter int BLINK_DIV = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       min_tick,
    input  logic       mode_btn,
    input  logic       inc_btn,
    output logic [4:0] hour,
    output logic [2:0] min_tens,
    output logic [3:0] min_ones,
    output logic [2:0] mode,
    output logic       blink
`ifdef HH_MM_ALARM_EN
    ,
    output logic       alarm_out
`endif
);

    state_t     state_q, state_d;
    hh_mm_t     time_q, time_d, time_inc;
    hh_mm_t     disp_q, disp_d;
    logic [7:0] blink_cnt;
    logic       blink_q;
    logic       tick_run;
    logic       edit;

    hh_mm_incr u_time_incr (
        .cur      (time_q),
        .carry_en (state_q == RUN),
        .field    ((state_q == SET_HOUR) ? FIELD_HOUR : FIELD_MIN),
        .nxt      (time_inc)
    );

`ifdef HH_MM_ALARM_EN
    hh_mm_t alarm_q, alarm_d, alarm_inc;
    logic   alarm_pulse_q;

    hh_mm_incr u_alarm_incr (
        .cur      (alarm_q),
        .carry_en (1'b0),
        .field    ((state_q == AL_HOUR) ? FIELD_HOUR : FIELD_MIN),
        .nxt      (alarm_inc)
    );
`endif

    always_comb begin
        state_d  = state_q;
        time_d   = time_q;
        tick_run = (state_q == RUN) && min_tick;
        edit     = inc_btn && !mode_btn;   // mode_btn wins over a simultaneous inc_btn

        if (mode_btn) begin
            unique case (state_q)
                RUN:      state_d = SET_HOUR;
                SET_HOUR: state_d = SET_MIN;
`ifdef HH_MM_ALARM_EN
                SET_MIN:  state_d = AL_HOUR;
                AL_HOUR:  state_d = AL_MIN;
                AL_MIN:   state_d = RUN;
`else
                SET_MIN:  state_d = RUN;
`endif
                default:  state_d = RUN;
            endcase
        end

        if (tick_run || (edit && (state_q == SET_HOUR || state_q == SET_MIN)))
            time_d = time_inc;

        disp_d = time_d;
`ifdef HH_MM_ALARM_EN
        alarm_d = alarm_q;
        if (edit && (state_q == AL_HOUR || state_q == AL_MIN))
            alarm_d = alarm_inc;
        if (state_d == AL_HOUR || state_d == AL_MIN)
            disp_d = alarm_d;
`endif
    end

    // NOTE: all state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RUN;
            time_q    <= '0;
            disp_q    <= '0;
            blink_cnt <= '0;
            blink_q   <= 1'b0;
`ifdef HH_MM_ALARM_EN
            alarm_q       <= ALARM_RESET;
            alarm_pulse_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            time_q  <= time_d;
            disp_q  <= disp_d;
            // Divider restarts on any state change and is held idle in RUN
            if (state_d != state_q || state_d == RUN) begin
                blink_cnt <= '0;
                blink_q   <= 1'b0;
            end else if (blink_cnt == 8'(BLINK_DIV - 1)) begin
                blink_cnt <= '0;
                blink_q   <= ~blink_q;
            end else begin
                blink_cnt <= blink_cnt + 8'd1;
            end
`ifdef HH_MM_ALARM_EN
            alarm_q       <= alarm_d;
            alarm_pulse_q <= tick_run && (time_d == alarm_q);
`endif
        end
    end

    assign hour     = disp_q.hour;
    assign min_tens = disp_q.min_tens;
    assign min_ones = disp_q.min_ones;
    assign mode     = state_q;
    assign blink    = blink_q;
`ifdef HH_MM_ALARM_EN
    assign alarm_out = alarm_pulse_q;
`endif

endmodule

// File: tb/tb_hh_mm_set_controller.sv
// Self-checking bench for hh_mm_set_controller: directed scenarios plus random
// stimulus against a minutes-of-day reference model. Honours HH_MM_ALARM_EN.
module tb_hh_mm_set_controller;

    localparam int BLINK_DIV = 8;

    logic       clk = 1'b0;
    logic       rst, min_tick, mode_btn, inc_btn;
    logic [4:0] hour;
    logic [2:0] min_tens;
    logic [3:0] min_ones;
    logic [2:0] mode;
    logic       blink;
`ifdef HH_MM_ALARM_EN
    logic       alarm_out;
    localparam int NUM_MODES = 5;
`else
    localparam int NUM_MODES = 3;
`endif

    hh_mm_set_controller #(.BLINK_DIV(BLINK_DIV)) dut (
        .clk      (clk),
        .rst      (rst),
        .min_tick (min_tick),
        .mode_btn (mode_btn),
        .inc_btn  (inc_btn),
        .hour     (hour),
        .min_tens (min_tens),
        .min_ones (min_ones),
        .mode     (mode),
        .blink    (blink)
`ifdef HH_MM_ALARM_EN
        ,
        .alarm_out(alarm_out)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: time and alarm as minutes since midnight
    int m_time, m_alarm, m_mode, m_since, m_pulse;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int bump_hour(input int v);
        return ((v / 60 + 1) % 24) * 60 + v % 60;
    endfunction

    function automatic int bump_min(input int v);
        return (v / 60) * 60 + (v % 60 + 1) % 60;
    endfunction

    task automatic model_edge(input bit r, input bit t, input bit m, input bit i);
        bit tick, ed;
        if (r) begin
            m_time = 0; m_mode = 0; m_since = 0; m_alarm = 360; m_pulse = 0;
            return;
        end
        tick    = (m_mode == 0) && t;
        ed      = i && !m;
        m_pulse = 0;
        if (tick) begin
            m_time = (m_time + 1) % 1440;
            m_pulse = (m_time == m_alarm) ? 1 : 0;
        end
        if (ed) begin
            case (m_mode)
                1: m_time  = bump_hour(m_time);
                2: m_time  = bump_min(m_time);
                3: m_alarm = bump_hour(m_alarm);
                4: m_alarm = bump_min(m_alarm);
                default: ;
            endcase
        end
        if (m) begin
            m_mode  = (m_mode + 1) % NUM_MODES;
            m_since = 0;
        end else begin
            m_since++;
        end
    endtask

    task automatic check_outputs(input string tag);
        int v;
        v = (m_mode >= 3) ? m_alarm : m_time;
        check({tag, ".hour"},  int'(hour),     v / 60);
        check({tag, ".tens"},  int'(min_tens), (v % 60) / 10);
        check({tag, ".ones"},  int'(min_ones), v % 10);
        check({tag, ".mode"},  int'(mode),     m_mode);
        check({tag, ".blink"}, int'(blink),    (m_mode == 0) ? 0 : (m_since / BLINK_DIV) % 2);
`ifdef HH_MM_ALARM_EN
        check({tag, ".alarm"}, int'(alarm_out), m_pulse);
`endif
    endtask

    task automatic step(input string tag, input bit r, input bit t, input bit m, input bit i);
        rst = r; min_tick = t; mode_btn = m; inc_btn = i;
        @(posedge clk);
        model_edge(r, t, m, i);
        #1;
        check_outputs(tag);
    endtask

    task automatic do_reset();
        step("rst", 1, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1; min_tick = 1'b0; mode_btn = 1'b0; inc_btn = 1'b0;
        m_time = 0; m_alarm = 360; m_mode = 0; m_since = 0; m_pulse = 0;

        // Reset state, checked against constants as well as the model
        do_reset();
        check("reset.hour", int'(hour), 0);
        check("reset.mode", int'(mode), 0);
        check("reset.blink", int'(blink), 0);

        // 60 minute ticks roll into the hour
        repeat (60) step("tick60", 0, 1, 0, 0);
        check("tick60.hour", int'(hour), 1);
        check("tick60.min", int'(min_tens) * 10 + int'(min_ones), 0);

        // Load 23:59, return to RUN, one tick wraps to 00:00
        step("to_seth", 0, 0, 1, 0);
        repeat (22) step("inc_h", 0, 0, 0, 1);
        step("to_setm", 0, 0, 1, 0);
        repeat (59) step("inc_m", 0, 0, 0, 1);
        check("load.hour", int'(hour), 23);
        check("load.min", int'(min_tens) * 10 + int'(min_ones), 59);
        while (m_mode != 0) step("to_run", 0, 0, 1, 0);
        step("wrap", 0, 1, 0, 0);
        check("wrap.hour", int'(hour), 0);
        check("wrap.min", int'(min_tens) * 10 + int'(min_ones), 0);

        // Blink cadence right after entering SET_HOUR
        do_reset();
        step("blk_entry", 0, 0, 1, 0);
        check("blink.entry", int'(blink), 0);
        for (int k = 1; k <= 2 * BLINK_DIV; k++) begin
            step("blk", 0, 0, 0, 0);
            if (k == BLINK_DIV - 1) check("blink.before", int'(blink), 0);
            if (k == BLINK_DIV)     check("blink.first",  int'(blink), 1);
            if (k == 2 * BLINK_DIV) check("blink.second", int'(blink), 0);
        end

        // 25 hour increments wrap to 1; ticks during edit are ignored
        repeat (25) step("inc25", 0, 0, 0, 1);
        check("inc25.hour", int'(hour), 1);
        repeat (3) step("frozen", 0, 1, 0, 0);
        check("frozen.min", int'(min_tens) * 10 + int'(min_ones), 0);

        // SET_MIN 59 -> 00 without hour carry; mode+inc together drops the inc
        do_reset();
        step("s36_h", 0, 0, 1, 0);
        repeat (5) step("s36_inch", 0, 0, 0, 1);
        step("s36_m", 0, 0, 1, 0);
        repeat (59) step("s36_incm", 0, 0, 0, 1);
        step("s36_wrap", 0, 0, 0, 1);
        check("minwrap.hour", int'(hour), 5);
        check("minwrap.min", int'(min_tens) * 10 + int'(min_ones), 0);
        step("s36_both", 0, 0, 1, 1);
`ifdef HH_MM_ALARM_EN
        check("both.mode", int'(mode), 3);
`else
        check("both.mode", int'(mode), 0);
        check("both.min", int'(min_tens) * 10 + int'(min_ones), 0);
`endif

`ifdef HH_MM_ALARM_EN
        // Alarm at 06:01 with time 06:00: one-cycle pulse after the tick
        do_reset();
        step("al_h", 0, 0, 1, 0);
        repeat (6) step("al_inch", 0, 0, 0, 1);
        step("al_m", 0, 0, 1, 0);
        step("al_ah", 0, 0, 1, 0);
        step("al_am", 0, 0, 1, 0);
        step("al_incm", 0, 0, 0, 1);
        step("al_run", 0, 0, 1, 0);
        check("alarm.idle", int'(alarm_out), 0);
        step("al_tick", 0, 1, 0, 0);
        check("alarm.pulse", int'(alarm_out), 1);
        step("al_after", 0, 0, 0, 0);
        check("alarm.drop", int'(alarm_out), 0);
`endif

        // Reset mid-edit overrides simultaneous inputs
        do_reset();
        step("r38_h", 0, 0, 1, 0);
        repeat (3) step("r38_inc", 0, 0, 0, 1);
        step("r38_rst", 1, 1, 1, 1);
        check("abort.hour", int'(hour), 0);
        check("abort.mode", int'(mode), 0);
`ifdef HH_MM_ALARM_EN
        repeat (3) step("r38_to_al", 0, 0, 1, 0);
        check("abort.alarm_hour", int'(hour), 6);
`endif

        // Random traffic against the model
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            step("rand",
                 ($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 11) == 0),
                 ($urandom_range(0, 2) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hh_mm_set_controller.md
HH_MM_SET_CONTROLLER -- requirements
Module: hh_mm_set_controller

Interface
REQ-001 Parameter BLINK_DIV, default 8, blink half-period in clk cycles; legal range 2..255.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 min_tick  input  1  one-cycle pulse per elapsed minute.
REQ-005 mode_btn  input  1  one-cycle pulse, already debounced; advances mode.
REQ-006 inc_btn  input  1  one-cycle pulse, already debounced; increments selected field.
REQ-007 hour  output  5  current hour, binary 0..23.
REQ-008 min_tens  output  3  minute tens digit 0..5.
REQ-009 min_ones  output  4  minute ones digit 0..9.
REQ-010 mode  output  3  current state encoding, per REQ-014.
REQ-011 blink  output  1  display-blank strobe for the field being edited.
REQ-012 alarm_out  output  1  alarm pulse; present only with ALARM_EN (REQ-030).

Function
REQ-013 All outputs shall be registered and shall change one cycle after the causing input pulse.
REQ-014 The FSM shall have states RUN=0, SET_HOUR=1, SET_MIN=2; with ALARM_EN also AL_HOUR=3, AL_MIN=4.
REQ-015 mode_btn transitions: RUN->SET_HOUR->SET_MIN->RUN; with ALARM_EN: SET_MIN->AL_HOUR->AL_MIN->RUN.
REQ-016 In RUN, min_tick shall increment time: min_ones 9->0 carries to min_tens; min_tens 5 with min_ones 9 -> 0:0 carries to hour; 23:59 -> 00:00.
REQ-017 In any non-RUN state, min_tick shall be ignored and time shall be frozen.
REQ-018 inc_btn in SET_HOUR shall increment hour modulo 24 (23->0), minutes unchanged.
REQ-019 inc_btn in SET_MIN shall increment minutes modulo 60 (59->00) with no carry into hour.
REQ-020 inc_btn in RUN shall be ignored.
REQ-021 mode_btn and inc_btn asserted in the same cycle: mode_btn shall take effect, inc_btn shall be dropped.
REQ-022 blink shall be 0 in RUN; in non-RUN states blink shall toggle every BLINK_DIV cycles, starting at 0 on state entry, and its divider shall restart on every state change.
REQ-023 In AL_HOUR/AL_MIN, the hour/min outputs shall display the alarm register and inc_btn shall edit it with the rules of REQ-018/REQ-019.

Reset
REQ-024 On rst, time shall be 00:00, mode RUN, blink 0, blink divider 0, alarm_out 0, alarm register 06:00.
REQ-025 rst shall override all simultaneous inputs and shall abort any set mode in progress without retaining partial edits.
REQ-026 Time edits shall apply to the live time register immediately; leaving SET_MIN shall not roll them back.

Configuration
REQ-027 Macro HH_MM_ALARM_EN shall compile the alarm feature in or out.
REQ-028 With HH_MM_ALARM_EN: states AL_HOUR/AL_MIN, a 5+3+4-bit alarm register and port alarm_out shall exist.
REQ-029 Without HH_MM_ALARM_EN: state encodings 3 and 4 and all alarm logic shall be absent, and mode_btn in SET_MIN shall return to RUN.
REQ-030 alarm_out shall pulse high for exactly one cycle when a RUN-state min_tick update makes time equal the alarm register; manual edits shall never raise it.

Structure
REQ-031 A shared package shall hold the state encodings, the HOUR_MAX=23, MIN_TENS_MAX=5 and MIN_ONES_MAX=9 constants, and an hh:mm struct type (5/3/4 bits).
REQ-032 A single sub-module hh_mm_incr shall compute the next hh:mm value, with inputs carry_en (minute-to-hour carry) and field select, and shall be instantiated for both the time and alarm registers.

Verification
REQ-033 Reset, then 60 min_tick pulses -> 01:00, mode 0, blink 0.
REQ-034 Load 23:59 in SET mode, return to RUN, 1 min_tick -> 00:00.
REQ-035 mode_btn once, then 25 inc_btn -> hour 1; 3 min_tick pulses during edit -> minutes unchanged; blink toggles every 8 cycles.
REQ-036 In SET_MIN at 59, inc_btn -> minutes 00 and hour unchanged; mode_btn together with inc_btn -> mode RUN, value unchanged.
REQ-037 ALARM_EN build: set alarm 06:01 with time 06:00 in RUN, 1 min_tick -> alarm_out high exactly 1 cycle, one cycle after the tick.
REQ-038 rst asserted while in SET_HOUR after 3 inc_btn -> next cycle 00:00, mode RUN, alarm 06:00.
